// File: rtl/anomaly_response_ctrl_if.sv
// Handshake bundle between the anomaly response controller and the pipeline.
// The master side drives detector/flush inputs; the slave side is the controller.
interface anomaly_response_ctrl_if;
    logic       enable;
    logic       anomaly_in;
    logic       ex_valid;
    logic       flush_ack;
    logic       stall_out;
    logic       flush_req;
    logic       det_clear_out;
    logic [7:0] escalation_count;
    logic [2:0] state_out;

    modport master (
        output enable, anomaly_in, ex_valid, flush_ack,
        input  stall_out, flush_req, det_clear_out,
        input  escalation_count, state_out
    );

    modport slave (
        input  enable, anomaly_in, ex_valid, flush_ack,
        output stall_out, flush_req, det_clear_out,
        output escalation_count, state_out
    );
endinterface

// File: rtl/anomaly_response_ctrl.sv
// Stall / escalate-to-flush / cooldown sequencer driven by the EX-stage
// anomaly detector; all outputs registered.
module anomaly_response_ctrl #(
    parameter int WINDOW_CYCLES   = 16,
    parameter int STALL_CYCLES    = 2,
    parameter int ESC_THRESHOLD   = 3,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    anomaly_response_ctrl_if.slave bus
);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam int HW = $clog2(ESC_THRESHOLD + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [WW-1:0] WIN_INIT = WW'(WINDOW_CYCLES - 1);
    localparam logic [SW-1:0] STL_INIT = SW'(STALL_CYCLES - 1);
    localparam logic [HW-1:0] HIT_MAX  = HW'(ESC_THRESHOLD);
    localparam logic [CW-1:0] CD_INIT  = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STALL   = 3'd1,
        S_MONITOR = 3'd2,
        S_FLUSH   = 3'd3,
        S_COOL    = 3'd4
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [HW-1:0] r_hit, w_nxt_hit, w_hit_inc;
    logic [WW-1:0] r_win, w_nxt_win, w_win_dec;
    logic [SW-1:0] r_stl, w_nxt_stl;
    logic [CW-1:0] r_cd, w_nxt_cd;
    logic [7:0]    r_esc, w_nxt_esc;
    logic          r_stall_o, r_flush_o, r_clr_o;
    logic          w_clr;
    logic          w_qual;

    assign w_qual    = bus.enable & bus.ex_valid & bus.anomaly_in;
    assign w_hit_inc = r_hit + HW'(1);
    assign w_win_dec = (r_win == '0) ? '0 : r_win - WW'(1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hit   = r_hit;
        w_nxt_win   = r_win;
        w_nxt_stl   = r_stl;
        w_nxt_cd    = r_cd;
        w_nxt_esc   = r_esc;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_qual) begin
                    w_nxt_hit   = HW'(1);
                    w_nxt_win   = WIN_INIT;
                    w_nxt_stl   = STL_INIT;
                    w_nxt_state = S_STALL;
                end
            end
            S_STALL: begin
                w_nxt_win = w_win_dec;
                if (!bus.enable) begin
                    w_nxt_hit   = '0;
                    w_nxt_state = S_IDLE;
                end else if (r_stl == '0) begin
                    w_nxt_state = S_MONITOR;
                end else begin
                    w_nxt_stl = r_stl - SW'(1);
                end
            end
            S_MONITOR: begin
                w_nxt_win = w_win_dec;
                // An anomaly in the expiry cycle still counts toward escalation.
                if (!bus.enable) begin
                    w_nxt_hit   = '0;
                    w_nxt_state = S_IDLE;
                end else if (w_qual) begin
                    w_nxt_hit = w_hit_inc;
                    if (w_hit_inc == HIT_MAX) begin
                        w_nxt_state = S_FLUSH;
                    end else begin
                        w_nxt_stl   = STL_INIT;
                        w_nxt_state = S_STALL;
                    end
                end else if (r_win == '0) begin
                    w_nxt_hit   = '0;
                    w_nxt_state = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (bus.flush_ack) begin
                    w_nxt_esc   = (r_esc == 8'hFF) ? r_esc : r_esc + 8'd1;
                    w_nxt_cd    = CD_INIT;
                    w_nxt_hit   = '0;
                    w_clr       = 1'b1;
                    w_nxt_state = S_COOL;
                end
            end
            S_COOL: begin
                if (r_cd == '0) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cd = r_cd - CW'(1);
                end
            end
            default: begin
                w_nxt_hit   = '0;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_hit     <= '0;
            r_win     <= '0;
            r_stl     <= '0;
            r_cd      <= '0;
            r_esc     <= '0;
            r_stall_o <= 1'b0;
            r_flush_o <= 1'b0;
            r_clr_o   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_hit     <= w_nxt_hit;
            r_win     <= w_nxt_win;
            r_stl     <= w_nxt_stl;
            r_cd      <= w_nxt_cd;
            r_esc     <= w_nxt_esc;
            r_stall_o <= (w_nxt_state == S_STALL) || (w_nxt_state == S_FLUSH);
            r_flush_o <= (w_nxt_state == S_FLUSH);
            r_clr_o   <= w_clr;
        end
    end

    assign bus.stall_out        = r_stall_o;
    assign bus.flush_req        = r_flush_o;
    assign bus.det_clear_out    = r_clr_o;
    assign bus.escalation_count = r_esc;
    assign bus.state_out        = r_state;
endmodule

// File: tb/tb_anomaly_response_ctrl.sv
// Directed bench for anomaly_response_ctrl: vector table plus hand sequences
// for reset, saturation and asynchronous reset during a flush request.
module tb_anomaly_response_ctrl;
    logic clk = 1'b0;
    logic reset;

    anomaly_response_ctrl_if ifc();

    anomaly_response_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         n;
        logic       en, ev, an, ack;
        logic       stl, fl, clr;
        logic [7:0] esc;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, int en, int ev, int an, int ack,
                                int stl, int fl, int clr, int esc, int st);
        vec_t v;
        v.n   = n;
        v.en  = 1'(en);
        v.ev  = 1'(ev);
        v.an  = 1'(an);
        v.ack = 1'(ack);
        v.stl = 1'(stl);
        v.fl  = 1'(fl);
        v.clr = 1'(clr);
        v.esc = 8'(esc);
        v.st  = 3'(st);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input logic en, input logic ev, input logic an,
                       input logic ack);
        ifc.enable     = en;
        ifc.ex_valid   = ev;
        ifc.anomaly_in = an;
        ifc.flush_ack  = ack;
    endtask

    task automatic chk_all(input string tag, input logic stl, input logic fl,
                           input logic clr, input logic [7:0] esc,
                           input logic [2:0] st);
        chk({tag, " stall"}, 8'(ifc.stall_out), 8'(stl));
        chk({tag, " flush"}, 8'(ifc.flush_req), 8'(fl));
        chk({tag, " clr"},   8'(ifc.det_clear_out), 8'(clr));
        chk({tag, " esc"},   ifc.escalation_count, esc);
        chk({tag, " state"}, 8'(ifc.state_out), 8'(st));
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (ifc.state_out == st) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " reached"}, 8'(ok), 8'd1);
    endtask

    logic [7:0] exp_esc;

    initial begin
        // reset held low under random inputs
        reset = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
        end
        drv(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("post%0d", i), 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
        end

        // escalation: anomalies 4 cycles apart, ack after 5 cycles of request
        add(1, 1,1,1,0, 1,0,0,0,1);
        add(1, 1,1,0,0, 1,0,0,0,1);
        add(2, 1,1,0,0, 0,0,0,0,2);
        add(1, 1,1,1,0, 1,0,0,0,1);
        add(1, 1,1,0,0, 1,0,0,0,1);
        add(2, 1,1,0,0, 0,0,0,0,2);
        add(1, 1,1,1,0, 1,1,0,0,3);
        add(4, 1,1,1,0, 1,1,0,0,3);
        add(1, 1,1,0,1, 0,0,1,1,4);
        add(3, 1,1,1,0, 0,0,0,1,4);
        add(4, 1,1,1,1, 0,0,0,1,4);
        add(1, 1,1,1,0, 0,0,0,1,0);
        add(1, 1,1,0,0, 0,0,0,1,0);
        // single anomaly: 2-cycle stall, idle 16 cycles after entry
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(14,1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,0,0, 0,0,0,1,0);
        // masking by ex_valid, enable and STALL state
        add(2, 1,0,1,0, 0,0,0,1,0);
        add(1, 0,1,1,0, 0,0,0,1,0);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,1,0, 0,0,0,1,2);
        add(2, 1,1,0,0, 0,0,0,1,2);
        add(2, 1,0,1,0, 0,0,0,1,2);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(7, 1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,0,0, 0,0,0,1,0);
        // two anomalies, window expires, new window restarts at one hit
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(2, 1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(10,1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,0,0, 0,0,0,1,0);
        add(2, 1,1,0,0, 0,0,0,1,0);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(2, 1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(10,1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,0,0, 0,0,0,1,0);
        // anomaly in the expiry cycle counts; flush completes with enable low
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(2, 1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,1,0, 1,0,0,1,1);
        add(1, 1,1,0,0, 1,0,0,1,1);
        add(10,1,1,0,0, 0,0,0,1,2);
        add(1, 1,1,1,0, 1,1,0,1,3);
        add(2, 0,1,1,0, 1,1,0,1,3);
        add(1, 0,1,0,1, 0,0,1,2,4);
        add(7, 0,1,0,0, 0,0,0,2,4);
        add(1, 0,1,0,0, 0,0,0,2,0);
        // enable drop in STALL and MONITOR clears the hit count
        add(1, 1,1,1,0, 1,0,0,2,1);
        add(1, 0,1,0,0, 0,0,0,2,0);
        add(1, 1,1,1,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 0,0,0,2,2);
        add(1, 1,1,1,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 0,0,0,2,2);
        add(1, 0,1,0,0, 0,0,0,2,0);
        add(1, 1,1,1,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 1,0,0,2,1);
        add(1, 1,1,0,0, 0,0,0,2,2);
        add(1, 1,1,1,0, 1,0,0,2,1);
        add(1, 0,1,0,0, 0,0,0,2,0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                drv(tbl[i].en, tbl[i].ev, tbl[i].an, tbl[i].ack);
                @(posedge clk);
                #1;
                chk_all($sformatf("v%0d.%0d", i, r), tbl[i].stl, tbl[i].fl,
                        tbl[i].clr, tbl[i].esc, tbl[i].st);
            end
        end

        // saturation of the flush counter
        exp_esc = 8'd2;
        for (int k = 0; k < 256; k++) begin
            drv(1'b1, 1'b1, 1'b1, 1'b0);
            wait_state(3'd3, $sformatf("sat%0d freq", k));
            drv(1'b1, 1'b1, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            exp_esc = (exp_esc == 8'd255) ? exp_esc : exp_esc + 8'd1;
            chk($sformatf("sat%0d esc", k), ifc.escalation_count, exp_esc);
            drv(1'b1, 1'b1, 1'b0, 1'b0);
            wait_state(3'd0, $sformatf("sat%0d idle", k));
        end
        chk("sat final", ifc.escalation_count, 8'd255);

        // asynchronous reset while a flush is requested
        drv(1'b1, 1'b1, 1'b1, 1'b0);
        wait_state(3'd3, "arst freq");
        chk("arst pre flush", 8'(ifc.flush_req), 8'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("arst", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
        drv(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst rel", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
